demux_1bit_buffered: RTL and testbench
======================================

Name: demux_1bit_buffered

Overview:
- Write-side counterpart of the datapath 2:1 selector. Takes one word_size-bit stream with a valid/ready handshake and steers each word to one of two destination channels using a 1-bit select.
- Each destination has its own 2-entry FIFO, so one stalled consumer does not block words bound for the other.
- Sits between the ALU/load result bus and two consumers, e.g. register-file write port (ch0) and store/IO path (ch1).

Parameters:
- word_size, 32, data width of input and both outputs
- count_width, 16, width of per-channel delivered-word counters

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the input word this cycle
- in_select  input  1  destination: 0 = ch0, 1 = ch1
- in_data  input  word_size  input word
- out_valid0  output  1  ch0 head word valid
- out_ready0  input  1  ch0 consumer takes head word
- out_data0  output  word_size  ch0 head word
- out_valid1  output  1  ch1 head word valid
- out_ready1  input  1  ch1 consumer takes head word
- out_data1  output  word_size  ch1 head word
- count0  output  count_width  words delivered on ch0
- count1  output  count_width  words delivered on ch1

Behaviour:
- Reset, when rst_n = 0 at a clk edge:
  - both FIFOs emptied (read/write pointers and occupancy = 0)
  - out_valid0 = out_valid1 = 0; out_data0 = out_data1 = 0
  - count0 = count1 = 0
  - Reset mid-transfer discards all buffered words. No handshake completes on a reset cycle.
- Handshakes:
  - Push occurs when in_valid & in_ready at the edge.
  - Pop on channel k occurs when out_validk & out_readyk at the edge.
- in_ready = (in_select ? occ1 : occ0) != 2.
  - Depends only on in_select and registered occupancy. There is no combinational path from out_ready0/1 to in_ready.
  - in_ready is meaningful regardless of in_valid.
- Per-channel FIFO:
  - Depth 2, 1-bit pointers that wrap 1 -> 0, occupancy 0..2.
  - out_validk = (occk != 0).
  - out_datak = entry at the read pointer. It must hold stable while out_validk = 1 and no pop occurs.
- Latency: a word pushed at edge N is visible on its channel's outputs after edge N (one cycle). There is no bypass from in_data to out_data.
- Simultaneous push and pop on the same channel:
  - Occupancy is unchanged and both pointers advance.
  - When occ = 2, push is blocked because in_ready = 0, even if a pop happens that cycle.
  - When occ = 1, the popped word is the old head and the new word becomes the head.
- Pushes to one channel are independent of pops on the other channel. Both channels may pop in the same cycle.
- Ordering: order is preserved within a channel. No ordering relation exists between channels.
- Counters: countk increments by 1 on every pop of channel k and wraps from 2^count_width-1 to 0.
- X on in_select while in_valid = 1 is a protocol violation. Behaviour is undefined; the bench must not drive it.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles with in_valid = 1, in_data = 32'hDEADBEEF, in_select = 0 -> after release, out_valid0/1 = 0, count0/1 = 0, and no word appears.
- Basic steering:
  - push 32'h11111111 with select = 0, then 32'h22222222 with select = 1, both out_ready = 1
  - -> out_data0 = 32'h11111111 one cycle after its push
  - -> out_data1 = 32'h22222222 one cycle after its push
  - -> count0 = count1 = 1
- Full/backpressure:
  - out_ready0 = 0; push 32'hA, 32'hB, 32'hC to ch0
  - -> A and B accepted, in_ready = 0 on C, out_data0 holds 32'hA
  - -> a push of 32'hD to ch1 is still accepted the same cycle
  - raise out_ready0 -> A, B, then C delivered in order
- Simultaneous push/pop:
  - ch0 occ = 1 holding 32'h5; push 32'h6 with out_ready0 = 1
  - -> 32'h5 popped, occ stays 1, out_data0 = 32'h6 next cycle
- Reset mid-operation: both FIFOs full; assert rst_n = 0 for one cycle -> all valids 0 next cycle and the buffered words are never delivered.
- Counter wrap: with count_width = 4, deliver 17 words on ch1 -> count1 = 1 and count0 = 0.

Source files
------------

// File: rtl/demux_1bit_buffered.sv
// 1-to-2 write-side steering block: one valid/ready input stream, two independently
// buffered output channels (2-entry FIFO each) plus per-channel delivered-word counters.

module demux_1bit_buffered_chan #(
    parameter int word_size   = 32,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [word_size-1:0]   push_data,
    input  logic                   pop_ready,
    output logic                   valid,
    output logic                   full,
    output logic [word_size-1:0]   data,
    output logic [count_width-1:0] count
);
    logic [1:0][word_size-1:0] mem;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                occ;
    logic                      pop;

    assign valid = (occ != 2'd0);
    assign full  = (occ == 2'd2);
    assign pop   = valid & pop_ready;
    assign data  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                count  <= count + {{(count_width-1){1'b0}}, 1'b1};
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module demux_1bit_buffered #(
    parameter int word_size   = 32,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_select,
    input  logic [word_size-1:0]   in_data,
    output logic                   out_valid0,
    input  logic                   out_ready0,
    output logic [word_size-1:0]   out_data0,
    output logic                   out_valid1,
    input  logic                   out_ready1,
    output logic [word_size-1:0]   out_data1,
    output logic [count_width-1:0] count0,
    output logic [count_width-1:0] count1
);
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0]                  ch_push;
    logic [NUM_CH-1:0]                  ch_ready;
    logic [NUM_CH-1:0]                  ch_valid;
    logic [NUM_CH-1:0]                  ch_full;
    logic [NUM_CH-1:0][word_size-1:0]   ch_data;
    logic [NUM_CH-1:0][count_width-1:0] ch_count;

    // in_ready looks only at registered fullness, never at the consumers' ready.
    assign in_ready = ~ch_full[in_select];
    assign ch_ready = {out_ready1, out_ready0};

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            assign ch_push[k] = in_valid & in_ready & (in_select == k[0]);

            demux_1bit_buffered_chan #(
                .word_size   (word_size),
                .count_width (count_width)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (ch_push[k]),
                .push_data (in_data),
                .pop_ready (ch_ready[k]),
                .valid     (ch_valid[k]),
                .full      (ch_full[k]),
                .data      (ch_data[k]),
                .count     (ch_count[k])
            );
        end
    endgenerate

    assign out_valid0 = ch_valid[0];
    assign out_valid1 = ch_valid[1];
    assign out_data0  = ch_data[0];
    assign out_data1  = ch_data[1];
    assign count0     = ch_count[0];
    assign count1     = ch_count[1];
endmodule

// File: tb/tb_demux_1bit_buffered.sv
// Directed bench for demux_1bit_buffered: reset, steering, backpressure, push/pop overlap,
// mid-run reset and counter wrap (counters built 4 bits wide).

module tb_demux_1bit_buffered;
    localparam int WS = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_select;
    logic [WS-1:0] in_data;
    logic          out_valid0;
    logic          out_ready0;
    logic [WS-1:0] out_data0;
    logic          out_valid1;
    logic          out_ready1;
    logic [WS-1:0] out_data1;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    int checks = 0;
    int errors = 0;

    demux_1bit_buffered #(.word_size(WS), .count_width(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_select  (in_select),
        .in_data    (in_data),
        .out_valid0 (out_valid0),
        .out_ready0 (out_ready0),
        .out_data0  (out_data0),
        .out_valid1 (out_valid1),
        .out_ready1 (out_ready1),
        .out_data1  (out_data1),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_select = 1'b0; in_data = 32'hDEADBEEF;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        #1;

        // Reset held 3 cycles with a word offered
        repeat (3) step();
        chk("rst_valid0", WS'(out_valid0), 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("rst_valid0_after", WS'(out_valid0), 0);
        chk("rst_valid1_after", WS'(out_valid1), 0);
        chk("rst_count0", WS'(count0), 0);
        chk("rst_count1", WS'(count1), 0);
        chk("rst_data0", out_data0, 0);
        chk("rst_data1", out_data1, 0);
        chk("rst_in_ready", WS'(in_ready), 1);

        // Basic steering
        in_valid = 1'b1; in_select = 1'b0; in_data = 32'h11111111;
        step();
        chk("steer_v0", WS'(out_valid0), 1);
        chk("steer_d0", out_data0, 32'h11111111);
        in_select = 1'b1; in_data = 32'h22222222;
        step();
        chk("steer_v0_drained", WS'(out_valid0), 0);
        chk("steer_cnt0", WS'(count0), 1);
        chk("steer_v1", WS'(out_valid1), 1);
        chk("steer_d1", out_data1, 32'h22222222);
        in_valid = 1'b0;
        step();
        chk("steer_v1_drained", WS'(out_valid1), 0);
        chk("steer_cnt1", WS'(count1), 1);

        // Full / backpressure on ch0, ch1 unaffected
        out_ready0 = 1'b0;
        in_valid = 1'b1; in_select = 1'b0; in_data = 32'hA;
        step();
        chk("bp_headA", out_data0, 32'hA);
        in_data = 32'hB;
        step();
        in_data = 32'hC;
        #1;
        chk("bp_full_ready0", WS'(in_ready), 0);
        in_select = 1'b1; in_data = 32'hD;
        #1;
        chk("bp_ready1", WS'(in_ready), 1);
        step();
        chk("bp_v1_D", WS'(out_valid1), 1);
        chk("bp_d1_D", out_data1, 32'hD);
        chk("bp_hold_A", out_data0, 32'hA);
        in_select = 1'b0; in_data = 32'hC;
        #1;
        chk("bp_C_blocked", WS'(in_ready), 0);
        step();
        chk("bp_hold_A2", out_data0, 32'hA);
        chk("bp_v0", WS'(out_valid0), 1);
        chk("bp_cnt1", WS'(count1), 2);
        in_valid = 1'b0; out_ready0 = 1'b1;
        step();
        chk("bp_headB", out_data0, 32'hB);
        chk("bp_cnt0_2", WS'(count0), 2);
        step();
        chk("bp_empty", WS'(out_valid0), 0);
        in_valid = 1'b1; in_data = 32'hC;
        step();
        chk("bp_headC", out_data0, 32'hC);
        in_valid = 1'b0;
        step();
        chk("bp_cnt0_4", WS'(count0), 4);

        // Simultaneous push/pop with one word buffered
        out_ready0 = 1'b0; in_valid = 1'b1; in_select = 1'b0; in_data = 32'h5;
        step();
        chk("pp_head5", out_data0, 32'h5);
        out_ready0 = 1'b1; in_data = 32'h6;
        step();
        chk("pp_v0", WS'(out_valid0), 1);
        chk("pp_head6", out_data0, 32'h6);
        chk("pp_cnt0", WS'(count0), 5);
        in_valid = 1'b0;
        step();
        chk("pp_drained", WS'(out_valid0), 0);
        chk("pp_cnt0_6", WS'(count0), 6);

        // Reset with both FIFOs full
        out_ready0 = 1'b0; out_ready1 = 1'b0; in_valid = 1'b1;
        in_select = 1'b0; in_data = 32'h100; step();
        in_data = 32'h101; step();
        in_select = 1'b1; in_data = 32'h200; step();
        in_data = 32'h201; step();
        chk("mr_full1", WS'(in_ready), 0);
        in_select = 1'b0;
        #1;
        chk("mr_full0", WS'(in_ready), 0);
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        chk("mr_v0", WS'(out_valid0), 0);
        chk("mr_v1", WS'(out_valid1), 0);
        chk("mr_cnt0", WS'(count0), 0);
        chk("mr_cnt1", WS'(count1), 0);
        rst_n = 1'b1; out_ready0 = 1'b1; out_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_word0", WS'(out_valid0), 0);
            chk("mr_no_word1", WS'(out_valid1), 0);
        end
        chk("mr_cnt_stay", WS'({count1, count0}), 0);

        // 17 deliveries on ch1 with 4-bit counters -> wraps to 1
        in_valid = 1'b1; in_select = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'h3000 + i;
            step();
            chk("wrap_data", out_data1, 32'h3000 + i);
        end
        in_valid = 1'b0;
        step();
        chk("wrap_cnt1", WS'(count1), 1);
        chk("wrap_cnt0", WS'(count0), 0);
        chk("wrap_empty", WS'(out_valid1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
